// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared defaults, blank-cell values and fill FSM state type for the console text path
package console_pkg;

   localparam int FONT_WIDTH_DEF  = 8;
   localparam int FONT_HEIGHT_DEF = 16;
   localparam int COLUMNS_DEF     = 80;
   localparam int ROWS_DEF        = 25;

   localparam logic [7:0] BLANK_CODEPOINT = 8'h20;
   localparam logic [7:0] DEFAULT_ATTR    = 8'h07;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SCROLL
   } fill_state_t;

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port cell RAM, one write port and one registered read port
module text_ram #(
   parameter int DEPTH  = 2000,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_pixel,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data
);

   logic [15:0] mem [DEPTH];

   // Read samples the array before this edge's write lands, so a same-cell collision returns old data.
   always_ff @(posedge clk_pixel) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - console text cell store: pixel fetch, host writes, clear and ring-buffer scroll
// Optional cursor attribute swap is built when TEXT_BUFFER_CURSOR_EN is defined.
module text_buffer
   import console_pkg::*;
#(
   parameter int         BIT_WIDTH   = 12,
   parameter int         BIT_HEIGHT  = 11,
   parameter int         FONT_WIDTH  = FONT_WIDTH_DEF,
   parameter int         FONT_HEIGHT = FONT_HEIGHT_DEF,
   parameter int         COLUMNS     = COLUMNS_DEF,
   parameter int         ROWS        = ROWS_DEF,
   parameter logic [7:0] CLEAR_ATTR  = DEFAULT_ATTR
) (
   input  logic                       clk_pixel,
   input  logic                       reset_n,
   input  logic [BIT_WIDTH-1:0]       cx,
   input  logic [BIT_HEIGHT-1:0]      cy,
   output logic [7:0]                 codepoint,
   output logic [7:0]                 attribute,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [$clog2(COLUMNS)-1:0] wr_col,
   input  logic [$clog2(ROWS)-1:0]    wr_row,
   input  logic [7:0]                 wr_codepoint,
   input  logic [7:0]                 wr_attribute,
   input  logic                       clear_req,
   input  logic                       scroll_req,
`ifdef TEXT_BUFFER_CURSOR_EN
   input  logic [$clog2(COLUMNS)-1:0] cursor_col,
   input  logic [$clog2(ROWS)-1:0]    cursor_row,
   input  logic                       cursor_on,
`endif
   output logic                       busy
);

   localparam int COL_W  = $clog2(COLUMNS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int CELLS  = COLUMNS * ROWS;
   localparam int ADDR_W = $clog2(CELLS);
   localparam int FW_SH  = $clog2(FONT_WIDTH);
   localparam int FH_SH  = $clog2(FONT_HEIGHT);
   localparam int CX_W   = BIT_WIDTH - FW_SH;
   localparam int CY_W   = BIT_HEIGHT - FH_SH;

   localparam logic [CX_W-1:0]   COLS_CX   = CX_W'(COLUMNS);
   localparam logic [CY_W-1:0]   ROWS_CY   = CY_W'(ROWS);
   localparam logic [COL_W:0]    COLS_LIM  = (COL_W + 1)'(COLUMNS);
   localparam logic [ROW_W:0]    ROWS_LIM  = (ROW_W + 1)'(ROWS);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLUMNS);

   // Logical row to physical row through the ring offset; both operands are < ROWS so one subtract suffices.
   function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] lrow,
                                                 input logic [ROW_W-1:0] top);
      logic [ROW_W:0] sum;
      sum = {1'b0, lrow} + {1'b0, top};
      if (sum >= ROWS_LIM) begin
         sum = sum - ROWS_LIM;
      end
      return sum[ROW_W-1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                   input logic [COL_W-1:0] col);
      return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
   endfunction

   fill_state_t       state, state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] fill_addr;
   logic [ROW_W-1:0]  top_row;
   logic              fill_we;

   logic [CX_W-1:0]   col_q;
   logic [CY_W-1:0]   lrow_q;
   logic              rd_in_range;
   logic [ADDR_W-1:0] rd_addr;
   logic              in_range_q;
   logic [15:0]       rd_data;
   logic [7:0]        attr_sel;

   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [15:0]       ram_wr_data;

   logic              unused_low_bits;
   assign unused_low_bits = ^{cx[FW_SH-1:0], cy[FH_SH-1:0]};

   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      busy       = 1'b1;
      fill_we    = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            if (clear_req) begin
               state_next = CLEAR;
            end else if (scroll_req) begin
               state_next = SCROLL;
            end
         end
         CLEAR: begin
            fill_we = 1'b1;
            if (cnt == LAST_CELL) begin
               state_next = IDLE;
            end
         end
         SCROLL: begin
            // cnt 0 advances top_row; cnt 1..COLUMNS blank the row that just rotated to the bottom.
            fill_we = (cnt != '0);
            if (cnt == COLS_A) begin
               state_next = IDLE;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         fill_addr <= '0;
         top_row   <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (clear_req) begin
                  fill_addr <= '0;
                  top_row   <= '0;
               end else if (scroll_req) begin
                  fill_addr <= cell_addr(top_row, '0);
               end
            end
            CLEAR: begin
               cnt       <= cnt + 1'b1;
               fill_addr <= fill_addr + 1'b1;
            end
            SCROLL: begin
               cnt <= cnt + 1'b1;
               if (cnt == '0) begin
                  top_row <= (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
               end else begin
                  fill_addr <= fill_addr + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      host_we     = wr_valid && wr_ready &&
                    ({1'b0, wr_col} < COLS_LIM) && ({1'b0, wr_row} < ROWS_LIM);
      host_addr   = cell_addr(wrap_row(wr_row, top_row), wr_col);
      ram_we      = fill_we || host_we;
      ram_wr_addr = fill_we ? fill_addr : host_addr;
      ram_wr_data = fill_we ? {CLEAR_ATTR, BLANK_CODEPOINT} : {wr_attribute, wr_codepoint};
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         col_q  <= '0;
         lrow_q <= '0;
      end else begin
         col_q  <= cx[BIT_WIDTH-1:FW_SH];
         lrow_q <= cy[BIT_HEIGHT-1:FH_SH];
      end
   end

   always_comb begin
      rd_in_range = (col_q < COLS_CX) && (lrow_q < ROWS_CY);
      rd_addr     = cell_addr(wrap_row(lrow_q[ROW_W-1:0], top_row), col_q[COL_W-1:0]);
   end

   text_ram #(
      .DEPTH  (CELLS),
      .ADDR_W (ADDR_W)
   ) u_text_ram (
      .clk_pixel (clk_pixel),
      .we        (ram_we),
      .wr_addr   (ram_wr_addr),
      .wr_data   (ram_wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

`ifdef TEXT_BUFFER_CURSOR_EN
   logic cursor_hit_q;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         cursor_hit_q <= 1'b0;
      end else begin
         cursor_hit_q <= cursor_on && (col_q == CX_W'(cursor_col)) && (lrow_q == CY_W'(cursor_row));
      end
   end
`endif

   always_comb begin
      attr_sel = rd_data[15:8];
`ifdef TEXT_BUFFER_CURSOR_EN
      if (cursor_hit_q) begin
         attr_sel = {rd_data[11:8], rd_data[15:12]};
      end
`endif
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         in_range_q <= 1'b0;
         codepoint  <= '0;
         attribute  <= '0;
      end else begin
         in_range_q <= rd_in_range;
         codepoint  <= in_range_q ? rd_data[7:0] : 8'h00;
         attribute  <= in_range_q ? attr_sel : 8'h00;
      end
   end

endmodule
